// File: rtl/scan_sequencer.sv
// scan_sequencer: ping scheduler for the sonar front end.
// Each ping is a transmit burst followed by a listen window. ADC triggers are
// paced inside the listen window, and the beam angle walks back and forth
// across the scan sector between pings. Every output comes straight from a flop.
module scan_sequencer #(
  parameter int BURST_CYCLES    = 524288,
  parameter int LISTEN_CYCLES   = 16252928,
  parameter int SAMPLE_INTERVAL = 100,
  parameter int ANGLE_WIDTH     = 8,
  parameter int ANGLE_MIN       = -30,
  parameter int ANGLE_MAX       = 30,
  parameter int ANGLE_STEP      = 1,
  parameter int PINGS_PER_ANGLE = 8,
  localparam int EW = $clog2(BURST_CYCLES + LISTEN_CYCLES),
  localparam int PW = $clog2(PINGS_PER_ANGLE + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          hold_in,
  output logic                          burst_start_out,
  output logic                          burst_active_out,
  output logic                          sample_trigger_out,
  output logic                          listen_done_out,
  output logic [EW-1:0]                 elapsed_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          sweep_right_out,
  output logic [PW-1:0]                 ping_index_out,
  output logic                          sweep_wrap_out
);

  localparam int SW = $clog2(SAMPLE_INTERVAL);

  localparam logic [EW-1:0] BURST_LAST = EW'(BURST_CYCLES - 1);
  localparam logic [EW-1:0] PING_LAST  = EW'(BURST_CYCLES + LISTEN_CYCLES - 1);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLE_INTERVAL - 1);
  localparam logic [PW-1:0] PIDX_LAST  = PW'(PINGS_PER_ANGLE - 1);

  localparam logic signed [ANGLE_WIDTH-1:0] AMIN  = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] AMAX  = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH-1:0] ASTEP = ANGLE_WIDTH'(ANGLE_STEP);

  typedef enum logic [1:0] {IDLE, BURST, LISTEN} state_t;

  state_t                          state_q, state_d;
  logic [EW-1:0]                   elapsed_q, elapsed_d;
  logic [SW-1:0]                   samp_q, samp_d;      // listen cycle modulo SAMPLE_INTERVAL
  logic                            start_q, start_d;
  logic                            active_q, active_d;
  logic                            trig_q, trig_d;
  logic                            done_q, done_d;
  logic                            wrap_q, wrap_d;
  logic signed [ANGLE_WIDTH-1:0]   angle_q, angle_d;
  logic                            right_q, right_d;
  logic [PW-1:0]                   pidx_q, pidx_d;

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      samp_q    <= '0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      angle_q   <= '0;
      right_q   <= 1'b1;
      pidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      samp_q    <= samp_d;
      start_q   <= start_d;
      active_q  <= active_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      angle_q   <= angle_d;
      right_q   <= right_d;
      pidx_q    <= pidx_d;
    end
  end

  // Next state, ping timing and the angle sweep. Output flops load the value
  // describing the cycle that follows the edge, so pulses line up with state.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    samp_d    = '0;
    angle_d   = angle_q;
    right_d   = right_q;
    pidx_d    = pidx_q;
    wrap_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d   = BURST;
          elapsed_d = '0;
        end
      end
      BURST: begin
        elapsed_d = elapsed_q + EW'(1);
        if (elapsed_q == BURST_LAST) state_d = LISTEN;
      end
      LISTEN: begin
        if (elapsed_q == PING_LAST) begin
          // Ping ends here: advance the per-angle count, maybe step the beam.
          if (!hold_in) begin
            if (pidx_q == PIDX_LAST) begin
              pidx_d = '0;
              if (right_q) begin
                if (angle_q == AMAX) begin
                  angle_d = AMAX - ASTEP;
                  right_d = 1'b0;
                  wrap_d  = 1'b1;
                end else begin
                  angle_d = angle_q + ASTEP;
                end
              end else begin
                if (angle_q == AMIN) begin
                  angle_d = AMIN + ASTEP;
                  right_d = 1'b1;
                  wrap_d  = 1'b1;
                end else begin
                  angle_d = angle_q - ASTEP;
                end
              end
            end else begin
              pidx_d = pidx_q + PW'(1);
            end
          end
          // Going idle leaves elapsed parked at its last value.
          if (enable_in) begin
            state_d   = BURST;
            elapsed_d = '0;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          elapsed_d = elapsed_q + EW'(1);
          samp_d    = (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    start_d  = (state_d == BURST) && (elapsed_d == '0);
    active_d = (state_d == BURST);
    trig_d   = (state_d == LISTEN) && (samp_d == '0);
    done_d   = (state_d == LISTEN) && (elapsed_d == PING_LAST);
  end

  assign burst_start_out    = start_q;
  assign burst_active_out   = active_q;
  assign sample_trigger_out = trig_q;
  assign listen_done_out    = done_q;
  assign elapsed_out        = elapsed_q;
  assign beam_angle_out     = angle_q;
  assign sweep_right_out    = right_q;
  assign ping_index_out     = pidx_q;
  assign sweep_wrap_out     = wrap_q;

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Central ping scheduler for the sonar front end. It replaces the free-running burst PWM, the beam-angle sweep logic and the 1 MHz ADC trigger counter with a single state machine. Each ping is sequenced as transmit burst, then listen window. During the listen window it paces ADC sample triggers, and between pings it steps the beam angle back and forth across the scan sector. Its outputs drive the transmit beamformer gate, the SPI controllers' trigger, the sine LUT angle and the shared per-ping reset of the receive, time-of-flight and velocity blocks.

## Interface
Parameters:
- BURST_CYCLES, 524288: transmit-burst length in clocks; must be ≥ 1.
- LISTEN_CYCLES, 16252928: listen-window length in clocks; must be ≥ 1.
- SAMPLE_INTERVAL, 100: clocks between ADC triggers in the listen window; must be ≥ 2.
- ANGLE_WIDTH, 8: width of the signed beam-angle output.
- ANGLE_MIN, -30: lower sweep limit in degrees (signed).
- ANGLE_MAX, 30: upper sweep limit in degrees (signed). ANGLE_MAX − ANGLE_MIN must be a multiple of ANGLE_STEP.
- ANGLE_STEP, 1: angle increment per step; must be ≥ 1.
- PINGS_PER_ANGLE, 8: pings fired per angle before stepping; must be ≥ 1.

Ports:
- clk_in, in, 1: system clock (100 MHz).
- rst_in, in, 1: asynchronous, active-high reset.
- enable_in, in, 1: run request. Sampled only in IDLE and on the last LISTEN cycle.
- hold_in, in, 1: freezes the beam angle (manual point mode).
- burst_start_out, out, 1: one-cycle pulse on the first BURST cycle; used as the per-ping reset.
- burst_active_out, out, 1: high for every BURST cycle; gates the transmitter outputs.
- sample_trigger_out, out, 1: one-cycle ADC conversion trigger.
- listen_done_out, out, 1: one-cycle pulse on the last LISTEN cycle.
- elapsed_out, out, $clog2(BURST_CYCLES+LISTEN_CYCLES): clocks since the current burst_start.
- beam_angle_out, out, ANGLE_WIDTH: signed current steering angle.
- sweep_right_out, out, 1: 1 means the angle is increasing.
- ping_index_out, out, $clog2(PINGS_PER_ANGLE+1): count of pings completed at the current angle.
- sweep_wrap_out, out, 1: one-cycle pulse when the sweep direction reverses.

## Operation
- States:
  - IDLE, BURST and LISTEN.
  - Reset enters IDLE.
  - All outputs are registered.
- Reset values:
  - All pulses and burst_active_out are 0.
  - elapsed_out is 0 and ping_index_out is 0.
  - beam_angle_out is 0.
  - sweep_right_out is 1.
- IDLE:
  - If enable_in is 1, go to BURST on the next edge.
  - Otherwise stay in IDLE. elapsed_out holds its value.
- BURST:
  - Lasts exactly BURST_CYCLES cycles, then goes to LISTEN.
  - elapsed_out is 0 on the first BURST cycle and increments by 1 every cycle through BURST and LISTEN.
- LISTEN:
  - Lasts exactly LISTEN_CYCLES cycles.
  - sample_trigger_out fires on listen cycle 0, SAMPLE_INTERVAL, 2·SAMPLE_INTERVAL, and so on, provided the cycle is still inside the window.
  - On the last cycle, listen_done_out pulses.
  - Next state is BURST if enable_in is 1, otherwise IDLE.
- Dropping enable_in mid-ping does not abort the ping; the ping always completes.
- Angle stepping happens at each listen_done_out:
  - If hold_in is 1: ping_index_out and the angle are unchanged.
  - Else if ping_index_out == PINGS_PER_ANGLE−1: ping_index_out becomes 0 and the angle steps.
  - Otherwise ping_index_out increments by 1.
- Angle step rule:
  - Going right at ANGLE_MAX: the angle becomes ANGLE_MAX−ANGLE_STEP, direction flips, and sweep_wrap_out pulses.
  - Going left at ANGLE_MIN: the mirrored rule applies (angle becomes ANGLE_MIN+ANGLE_STEP, direction flips, sweep_wrap_out pulses).
  - Otherwise the angle moves ±ANGLE_STEP.
  - The first step out of reset goes 0 → +ANGLE_STEP.
- All angle arithmetic is signed ANGLE_WIDTH. Limits are never exceeded.

## Timing
- IDLE → BURST: with enable_in high at edge t, burst_start_out and burst_active_out are both 1 in the cycle after t.
- Back-to-back pings: ping period is exactly BURST_CYCLES+LISTEN_CYCLES clocks. The burst_start_out of the next ping is in the cycle immediately after listen_done_out.
- Angle and direction update: beam_angle_out and sweep_right_out update on the same edge that raises the next burst_start_out (or enters IDLE). They are therefore stable for the whole burst and listen window.
- sample_trigger_out: never asserted during BURST or IDLE.
- Asynchronous reset: rst_in asserted at any point, including mid-BURST, clears all state immediately.
- Reset release: the first burst occurs no earlier than one edge after rst_in deasserts with enable_in high.

## Test plan
All scenarios use BURST_CYCLES=4, LISTEN_CYCLES=20, SAMPLE_INTERVAL=5, PINGS_PER_ANGLE=2, ANGLE_MIN=-2, ANGLE_MAX=2, ANGLE_STEP=1.

- **Single ping:** pulse enable_in for 1 cycle from IDLE.
  - burst_active_out is high for 4 cycles, with burst_start_out on the first of them.
  - sample_trigger_out fires at elapsed_out 4, 9, 14 and 19.
  - listen_done_out fires at elapsed_out 23, then the block returns to IDLE.
- **Continuous sweep:** hold enable_in high.
  - Period is 24 cycles.
  - beam_angle_out per ping: 0,0,1,1,2,2,1,1,0,0,−1,−1,−2,−2,−1.
  - sweep_wrap_out pulses at the 2→1 and −2→−1 transitions.
- **Hold:** assert hold_in across 5 pings at angle 1. The angle stays at 1 and ping_index_out stays constant.
- **Enable drop mid-burst:** deassert enable_in in burst cycle 2. The ping completes through listen_done_out, then the block enters IDLE with no further burst_start_out.
- **Async reset mid-listen:** assert rst_in at elapsed_out=10.
  - Outputs go to reset values before the next edge: angle 0, sweep_right_out 1, no triggers.
  - After release with enable_in high, a fresh burst starts with elapsed_out=0.
